// File: rtl/cu_pkg.sv
// Shared definitions for the control unit: opcode map, FSM state encoding and
// the default memory-acknowledge wait limit.
package cu_pkg;

    localparam int ACK_TIMEOUT_DEFAULT = 15;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        MEMRD,
        MEMWR,
        EXEC,
        FAULT
    } cu_state_e;

endpackage

// File: rtl/cu_timeout.sv
// Memory-ack wait counter: counts waiting cycles, flags the last permitted one
// so the FSM can leave for FAULT on the following edge.
module cu_timeout
    import cu_pkg::*;
#(
    parameter int LIMIT = ACK_TIMEOUT_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + 8'd1;
        end
    end

    // Asserted during the LIMIT-th consecutive cycle without an acknowledge.
    assign expired = enable && !clear && (count_reg == 8'(LIMIT - 1));

endmodule

// File: rtl/control_unit.sv
// Multi-cycle CPU control unit: fetch/decode/memory/execute sequencing with
// memory-ack timeout, halt handling and retired-instruction counting.
module control_unit
    import cu_pkg::*;
#(
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       acc_load,
    output logic [3:0] alu_op,
    output logic       halted,
    output logic       fault,
    output logic [7:0] instr_count
);

    cu_state_e  state_reg, state_next;
    logic [3:0] op_reg;
    logic       halted_reg, halted_next;
    logic [7:0] count_reg;
    logic       waiting, wait_enable, wait_clear, expired, retire;

    // Leaving a wait state or seeing the ack both zero the counter, so every
    // FETCH/MEMRD/MEMWR visit starts counting from 0.
    assign waiting     = (state_reg == FETCH) || (state_reg == MEMRD) || (state_reg == MEMWR);
    assign wait_enable = waiting && !mem_ack;
    assign wait_clear  = !wait_enable;

    cu_timeout #(.LIMIT(ACK_TIMEOUT)) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (wait_clear),
        .enable  (wait_enable),
        .expired (expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            op_reg     <= '0;
            halted_reg <= 1'b0;
            count_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            halted_reg <= halted_next;
            if (state_reg == DECODE) begin
                op_reg <= opcode;
            end
            if (retire) begin
                count_reg <= count_reg + 8'd1;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        halted_next = halted_reg;
        mem_req     = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        acc_load    = 1'b0;
        alu_op      = 4'h0;
        retire      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next  = FETCH;
                    halted_next = 1'b0;
                end
            end
            FETCH: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                if (mem_ack) begin
                    ir_load    = 1'b1;
                    state_next = DECODE;
                end else if (expired) begin
                    state_next = FAULT;
                end
            end
            DECODE: begin
                pc_inc = 1'b1;
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR: state_next = MEMRD;
                    OP_STA:                                state_next = MEMWR;
                    OP_JMP, OP_JZ:                         state_next = EXEC;
                    OP_HLT: begin
                        state_next  = IDLE;
                        halted_next = 1'b1;
                        retire      = 1'b1;
                    end
                    OP_NOP: begin
                        state_next = FETCH;
                        retire     = 1'b1;
                    end
                    default: begin
                        state_next = FETCH;
                        retire     = 1'b1;
                    end
                endcase
            end
            MEMRD: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                if (mem_ack) begin
                    acc_load   = 1'b1;
                    alu_op     = op_reg;
                    retire     = 1'b1;
                    state_next = FETCH;
                end else if (expired) begin
                    state_next = FAULT;
                end
            end
            MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                if (mem_ack) begin
                    retire     = 1'b1;
                    state_next = FETCH;
                end else if (expired) begin
                    state_next = FAULT;
                end
            end
            EXEC: begin
                pc_load    = (op_reg == OP_JMP) || ((op_reg == OP_JZ) && zero);
                retire     = 1'b1;
                state_next = FETCH;
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign halted      = halted_reg;
    assign fault       = (state_reg == FAULT);
    assign instr_count = count_reg;

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have parameter ACK_TIMEOUT, default 15, giving the memory-ack wait limit in cycles (range 1..255).
REQ-002 The block SHALL have port clock, input, 1, the single system clock; all state changes on the rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, level; begins or resumes execution from IDLE.
REQ-005 The block SHALL have port opcode, input, 4, the opcode from the instruction register (instruction bits 3:0).
REQ-006 The block SHALL have port zero, input, 1, the accumulator-zero flag from the datapath.
REQ-007 The block SHALL have port mem_ack, input, 1, memory completion for the current request.
REQ-008 The block SHALL have ports mem_req, mem_read and mem_write, output, 1 each, giving the memory request and its direction.
REQ-009 The block SHALL have ports ir_load, pc_inc, pc_load and acc_load, output, 1 each, datapath strobes, each one cycle wide.
REQ-010 The block SHALL have port alu_op, output, 4, the ALU operation; it equals the latched opcode while acc_load is high and is 0 otherwise.
REQ-011 The block SHALL have ports halted and fault, output, 1 each, giving status.
REQ-012 The block SHALL have port instr_count, output, 8, the count of retired instructions.

Function
REQ-013 The FSM SHALL have states IDLE, FETCH, DECODE, MEMRD, MEMWR, EXEC and FAULT.
REQ-014 The opcode encodings SHALL be: 0 NOP, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 JMP, 8 JZ, F HLT; 9-E are illegal.
REQ-015 In IDLE, start=1 SHALL move the FSM to FETCH on the next edge and clear halted.
REQ-016 In FETCH the block SHALL hold mem_req=1 and mem_read=1; the cycle in which mem_ack=1 SHALL assert ir_load and move to DECODE.
REQ-017 DECODE SHALL last exactly one cycle, latch opcode internally and pulse pc_inc.
REQ-018 From DECODE, LDA and ADD through OR SHALL go to MEMRD, STA to MEMWR, JMP and JZ to EXEC, HLT to IDLE with halted=1, and NOP or illegal opcodes to FETCH.
REQ-019 In MEMRD the block SHALL hold mem_req=1 and mem_read=1; the ack cycle SHALL pulse acc_load with the latched alu_op, then go to FETCH.
REQ-020 In MEMWR the block SHALL hold mem_req=1 and mem_write=1; the ack cycle SHALL go to FETCH.
REQ-021 EXEC SHALL last one cycle; pc_load=1 for JMP, or for JZ when zero=1 in that cycle; then go to FETCH.
REQ-022 mem_read and mem_write SHALL never both be high, and neither SHALL be high without mem_req.
REQ-023 The request signals SHALL stay stable until mem_ack; a mem_ack seen outside FETCH, MEMRD or MEMWR SHALL be ignored.
REQ-024 A wait counter SHALL count cycles in FETCH, MEMRD or MEMWR without ack and clear on state entry; when it reaches ACK_TIMEOUT the FSM SHALL go to FAULT, deassert mem_req and set fault=1.
REQ-025 FAULT SHALL be left only by reset.
REQ-026 instr_count SHALL increment by 1 on every retired instruction, wrapping 255 to 0.
REQ-027 An instruction retires on the transition out of DECODE for NOP, illegal or HLT, out of EXEC, or on the ack of MEMRD or MEMWR.
REQ-028 Instruction latency SHALL be: NOP 2 cycles plus fetch wait; JMP/JZ 3 cycles plus fetch wait; memory operations 3 cycles plus both waits.
REQ-029 start held high while halted SHALL immediately restart fetch, since the PC is already incremented past HLT.

Reset
REQ-030 While reset=0 the FSM SHALL be IDLE and every strobe and mem_* output 0, with alu_op=0, halted=0, fault=0, instr_count=0 and the wait counter at 0.
REQ-031 Reset asserted mid-transaction SHALL drop mem_req asynchronously, with no completing strobe.

Structure
REQ-032 Package cu_pkg SHALL hold the opcode localparams, the state encoding and the ACK_TIMEOUT default.
REQ-033 The wait counter SHALL be the sub-module cu_timeout (clock, reset, clear, enable, expired); all other logic SHALL be flat.

Verification
REQ-034 The bench SHALL cover: reset, then start=1 with ack 1 cycle after each request, running 1,7 (LDA, JMP) -> ir_load twice, one acc_load with alu_op=1, pc_load=1 in EXEC, instr_count=2.
REQ-035 The bench SHALL cover: ADD with ack delayed 5 cycles in MEMRD -> mem_req held 6 cycles, acc_load 1 cycle with alu_op=3, no fault.
REQ-036 The bench SHALL cover: JZ with zero=0 then zero=1 -> pc_load 0 then 1; instr_count incremented by 2.
REQ-037 The bench SHALL cover: HLT -> IDLE with halted=1 and no further mem_req; start=1 -> halted=0 and FETCH the next cycle.
REQ-038 The bench SHALL cover: mem_ack never returned in FETCH -> fault=1 after 15 cycles, mem_req=0; only reset clears it.
REQ-039 The bench SHALL cover: reset pulled low during MEMWR with mem_req=1 -> all outputs 0 at once, and instr_count 255+1 -> 0.
